// File: rtl/pio_input_debounced.sv
// Avalon-MM input PIO: per-bit 2-FF synchroniser, debounce counter, edge capture
// and maskable level/edge interrupt.
module pio_input_debounced #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_TYPE        = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         sync_q1, sync_q2;
  logic [WIDTH-1:0]         db, db_next;
  logic [WIDTH-1:0][CW-1:0] cnt, cnt_next;
  logic [WIDTH-1:0]         rise, fall, edge_set, edge_clr;
  logic [WIDTH-1:0]         irq_mask, edgecapture;
  logic [31:0]              read_mux;
  logic                     wr_en;
  logic                     unused_wdata;

  assign wr_en = chipselect & ~write_n;
  // Upper writedata bits have no register behind them.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= in_port;
      sync_q2 <= sync_q1;
    end
  end

  // Counter only runs while the synchronised input disagrees with the accepted
  // state, so any glitch shorter than DEBOUNCE_CYCLES restarts it from zero.
  always_comb begin
    db_next  = db;
    cnt_next = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (DEBOUNCE_CYCLES == 0) begin
        db_next[i] = sync_q2[i];
      end else if (sync_q2[i] != db[i]) begin
        if (cnt[i] == CNT_LAST) db_next[i] = sync_q2[i];
        else                    cnt_next[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db  <= '0;
      cnt <= '0;
    end else begin
      db  <= db_next;
      cnt <= cnt_next;
    end
  end

  assign rise = ~db & db_next;
  assign fall = db & ~db_next;

  always_comb begin
    if (EDGE_TYPE == 0)      edge_set = rise;
    else if (EDGE_TYPE == 1) edge_set = fall;
    else                     edge_set = rise | fall;
  end

  assign edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    read_mux = '0;
    case (address)
      2'd0:    read_mux[WIDTH-1:0] = db;
      2'd2:    read_mux[WIDTH-1:0] = irq_mask;
      2'd3:    read_mux[WIDTH-1:0] = edgecapture;
      default: read_mux = '0;
    endcase
  end

  // Set is OR-ed after the clear so a same-clock edge survives a W1C write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask    <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~edge_clr) | edge_set;
      readdata    <= read_mux;
    end
  end

  assign irq = (IRQ_TYPE == 0) ? |(db & irq_mask) : |(edgecapture & irq_mask);

endmodule

// File: tb/tb_pio_input_debounced.sv
// Bench for pio_input_debounced: three parameter variants driven in parallel and
// compared every clock against a windowed debounce reference model.
`timescale 1ns/1ps
module tb_pio_input_debounced;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd [NI];
  logic          irq_o [NI];

  always #5 clk = ~clk;

  // dut 0: rising edge, level irq; dut 1: rising edge, edge irq; dut 2: any edge, edge irq
  pio_input_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(0), .IRQ_TYPE(0)) dut_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .in_port(in_port), .irq(irq_o[0]));
  pio_input_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_edge (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .in_port(in_port), .irq(irq_o[1]));
  pio_input_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(2), .IRQ_TYPE(1)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]), .in_port(in_port), .irq(irq_o[2]));

  // Reference model: a bit is accepted once the last N synchronised samples all
  // disagree with the accepted value.
  logic [W-1:0]  m_s1, m_s2, m_db;
  logic [W-1:0]  m_win [$];
  logic [W-1:0]  m_mask [NI];
  logic [W-1:0]  m_ec [NI];
  logic [31:0]   m_rd [NI];
  int            nvec, nerr;

  function automatic void m_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    m_win.delete();
    for (int i = 0; i < N; i++) m_win.push_back('0);
    for (int k = 0; k < NI; k++) begin
      m_mask[k] = '0; m_ec[k] = '0; m_rd[k] = '0;
    end
  endfunction

  function automatic logic m_irq(int k);
    return (k == 0) ? |(m_db & m_mask[k]) : |(m_ec[k] & m_mask[k]);
  endfunction

  task automatic bus(input logic [1:0] a, input logic we, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = ~we; writedata = d;
  endtask

  task automatic cycle();
    logic [W-1:0] samp, ndb, rise, fall, clr, setv;
    logic [31:0]  nrd;
    logic         wr, flip;
    @(posedge clk);
    wr   = chipselect && !write_n;
    samp = m_s2;
    m_win.push_back(samp);
    void'(m_win.pop_front());
    ndb = m_db;
    for (int b = 0; b < W; b++) begin
      flip = 1'b1;
      foreach (m_win[j]) if (m_win[j][b] == m_db[b]) flip = 1'b0;
      if (flip) ndb[b] = samp[b];
    end
    rise = ~m_db & ndb;
    fall = m_db & ~ndb;
    clr  = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int k = 0; k < NI; k++) begin
      nrd = '0;
      case (address)
        2'd0:    nrd[W-1:0] = m_db;
        2'd2:    nrd[W-1:0] = m_mask[k];
        2'd3:    nrd[W-1:0] = m_ec[k];
        default: nrd = '0;
      endcase
      m_rd[k] = nrd;
      setv = (k == 2) ? (rise | fall) : rise;
      m_ec[k] = (m_ec[k] & ~clr) | setv;
      if (wr && address == 2'd2) m_mask[k] = writedata[W-1:0];
    end
    m_db = ndb; m_s2 = m_s1; m_s1 = in_port;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    in_port = '0; bus(2'd0, 1'b0, 32'h0);
    reset_n = 1'b0; m_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      nvec++;
      if (rd[k] !== 32'h0 || irq_o[k] !== 1'b0) begin
        nerr++; $display("FAIL reset_hold dut%0d rd=%h irq=%b expected rd=0 irq=0", k, rd[k], irq_o[k]);
      end
    end
    reset_n = 1'b1;
    for (int a = 2; a <= 3; a++) begin
      bus(2'(a), 1'b0, 32'h0); cycle(); cycle();
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (rd[k] !== 32'h0 || rd[k] !== m_rd[k]) begin
          nerr++; $display("FAIL reset_read a=%0d dut%0d rd=%h expected 0", a, k, rd[k]);
        end
      end
    end
  endtask

  task automatic test_debounce();
    in_port = 4'b0001; bus(2'd0, 1'b0, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      cycle();
      nvec++;
      if (rd[0] !== ((i >= 7) ? 32'h1 : 32'h0)) begin
        nerr++; $display("FAIL debounce_latency clk=%0d rd=%h expected %h", i, rd[0], (i >= 7) ? 32'h1 : 32'h0);
      end
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq(k)) begin
          nerr++; $display("FAIL debounce dut%0d rd=%h irq=%b expected rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq(k));
        end
      end
    end
    bus(2'd3, 1'b0, 32'h0); cycle();
    nvec++;
    if (rd[1] !== 32'h1) begin
      nerr++; $display("FAIL debounce_edgecap rd=%h expected 00000001", rd[1]);
    end
  endtask

  task automatic test_bounce();
    bus(2'd0, 1'b0, 32'h0);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) begin
        in_port[1] = (r < 5) && (c < 3);
        cycle();
        nvec++;
        if (rd[0][1] !== 1'b0) begin
          nerr++; $display("FAIL bounce_data rep=%0d rd=%h expected bit1=0", r, rd[0]);
        end
        for (int k = 0; k < NI; k++) begin
          nvec++;
          if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq(k)) begin
            nerr++; $display("FAIL bounce dut%0d rd=%h irq=%b expected rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq(k));
          end
        end
      end
    end
    bus(2'd3, 1'b0, 32'h0); cycle();
    for (int k = 0; k < NI; k++) begin
      nvec++;
      if (rd[k][1] !== 1'b0 || rd[k] !== m_rd[k]) begin
        nerr++; $display("FAIL bounce_edgecap dut%0d rd=%h expected %h", k, rd[k], m_rd[k]);
      end
    end
  endtask

  task automatic test_irq_edge();
    bus(2'd3, 1'b1, 32'hF); cycle();
    bus(2'd2, 1'b1, 32'h2); cycle();
    bus(2'd0, 1'b0, 32'h0); in_port[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq(k)) begin
          nerr++; $display("FAIL irq_edge dut%0d rd=%h irq=%b expected rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq(k));
        end
      end
    end
    nvec++;
    if (irq_o[1] !== 1'b1) begin nerr++; $display("FAIL irq_edge_set irq=%b expected 1", irq_o[1]); end
    bus(2'd3, 1'b1, 32'h2); cycle();
    nvec++;
    if (irq_o[1] !== 1'b0) begin nerr++; $display("FAIL irq_edge_clear irq=%b expected 0", irq_o[1]); end
    bus(2'd0, 1'b0, 32'h0); in_port[1] = 1'b0;
    repeat (8) cycle();
    in_port[1] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) bus(2'd3, 1'b1, 32'h2);
      else if (i == 7) bus(2'd3, 1'b0, 32'h0);
      cycle();
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq(k)) begin
          nerr++; $display("FAIL set_vs_clear dut%0d rd=%h irq=%b expected rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq(k));
        end
      end
    end
    nvec++;
    if (rd[1][1] !== 1'b1 || irq_o[1] !== 1'b1) begin
      nerr++; $display("FAIL set_wins rd=%h irq=%b expected bit1=1 irq=1", rd[1], irq_o[1]);
    end
  endtask

  task automatic test_irq_level();
    bus(2'd2, 1'b1, 32'h8); cycle();
    bus(2'd0, 1'b0, 32'h0); in_port = 4'b1000;
    repeat (8) cycle();
    nvec++;
    if (irq_o[0] !== 1'b1) begin nerr++; $display("FAIL level_on irq=%b expected 1", irq_o[0]); end
    in_port[3] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      nvec++;
      if (irq_o[0] !== (i < 6)) begin
        nerr++; $display("FAIL level_release clk=%0d irq=%b expected %b", i, irq_o[0], i < 6);
      end
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq(k)) begin
          nerr++; $display("FAIL irq_level dut%0d rd=%h irq=%b expected rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq(k));
        end
      end
    end
    in_port[3] = 1'b1;
    repeat (8) cycle();
    bus(2'd2, 1'b1, 32'h0); cycle();
    nvec++;
    if (irq_o[0] !== 1'b0) begin nerr++; $display("FAIL level_mask_off irq=%b expected 0", irq_o[0]); end
  endtask

  task automatic test_any_edge();
    bus(2'd3, 1'b1, 32'hF); cycle();
    bus(2'd3, 1'b0, 32'h0); in_port[2] = 1'b1;
    repeat (9) cycle();
    nvec++;
    if (rd[2][2] !== 1'b1) begin nerr++; $display("FAIL any_rise rd=%h expected bit2=1", rd[2]); end
    bus(2'd3, 1'b1, 32'h4); cycle();
    bus(2'd3, 1'b0, 32'h0); cycle();
    nvec++;
    if (rd[2][2] !== 1'b0) begin nerr++; $display("FAIL any_clear rd=%h expected bit2=0", rd[2]); end
    in_port[2] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq(k)) begin
          nerr++; $display("FAIL any_edge dut%0d rd=%h irq=%b expected rd=%h irq=%b", k, rd[k], irq_o[k], m_rd[k], m_irq(k));
        end
      end
    end
    nvec++;
    if (rd[2][2] !== 1'b1 || rd[1][2] !== 1'b0) begin
      nerr++; $display("FAIL any_fall any=%h rising=%h expected bit2 1/0", rd[2], rd[1]);
    end
  endtask

  task automatic test_reset_mid();
    bus(2'd3, 1'b1, 32'hF); cycle();
    bus(2'd0, 1'b0, 32'h0); in_port[2] = 1'b1;
    repeat (4) cycle();
    reset_n = 1'b0; in_port = '0; m_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      nvec++;
      if (rd[k] !== 32'h0 || irq_o[k] !== 1'b0) begin
        nerr++; $display("FAIL async_reset dut%0d rd=%h irq=%b expected 0/0", k, rd[k], irq_o[k]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus(2'(i % 4), 1'b0, 32'h0);
      cycle();
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (rd[k] !== 32'h0 || rd[k] !== m_rd[k] || irq_o[k] !== 1'b0) begin
          nerr++; $display("FAIL reset_mid dut%0d clk=%0d rd=%h irq=%b expected 0/0", k, i, rd[k], irq_o[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    int b;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, W - 1);
        in_port[b] = ~in_port[b];
      end
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      cycle();
      for (int k = 0; k < NI; k++) begin
        nvec++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq(k)) begin
          nerr++; $display("FAIL random dut%0d step=%0d rd=%h irq=%b expected rd=%h irq=%b", k, i, rd[k], irq_o[k], m_rd[k], m_irq(k));
        end
      end
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    reset_n = 1'b1; in_port = '0;
    address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    m_reset();
    #1 reset_n = 1'b0;
    test_reset();
    test_debounce();
    test_bounce();
    test_irq_edge();
    test_irq_level();
    test_any_edge();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
